// File: rtl/dmem_responder.sv
//==============================================================================
// Module      : dmem_responder
// Description : Single-port data memory with a fixed wait-state response FSM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ready_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               state_q;
   logic [3:0]           cnt_q;
   logic                 we_q;
   logic                 fault_q;
   logic [c_IDX_W-1:0]   idx_q;
   logic [31:0]          wdata_q;
   logic [31:0]          rdata_q;
   logic                 ready_q;
   logic                 err_q;
   logic                 busy_q;
   logic [31:0]          mem_q [DEPTH];

   logic                 acc_fault;
   logic [c_IDX_W-1:0]   acc_idx;
   logic [c_IDX_W-1:0]   rd_idx;
   logic                 rd_fault;
   logic [31:0]          rd_word;

   // The full word index takes part in the range check so high bits never alias.
   assign acc_fault = (addr_i[1:0] != 2'b00) || ({2'b00, addr_i[31:2]} >= 32'(DEPTH));
   assign acc_idx   = addr_i[c_IDX_W+1:2];

   // With zero wait states the response is produced on the accepting edge,
   // so the read must use the live address rather than the latched one.
   assign rd_idx   = (state_q == ST_IDLE) ? acc_idx   : idx_q;
   assign rd_fault = (state_q == ST_IDLE) ? acc_fault : fault_q;
   assign rd_word  = rd_fault ? 32'd0 : mem_q[rd_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  wdata_q <= wdata_i;
                  idx_q   <= acc_idx;
                  fault_q <= acc_fault;
                  busy_q  <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= ST_RESP;
                     ready_q <= 1'b1;
                     err_q   <= acc_fault;
                     rdata_q <= rd_word;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= 4'(WAIT_CYCLES);
                  end
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= ST_RESP;
                  ready_q <= 1'b1;
                  err_q   <= fault_q;
                  rdata_q <= rd_word;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Storage is not reset; an asynchronous reset pulls the FSM out of RESP
   // before the closing edge, which suppresses the write.
   always_ff @(posedge clk) begin
      if ((state_q == ST_RESP) && we_q && !fault_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign rdata_o = rdata_q;
   assign ready_o = ready_q;
   assign err_o   = err_q;
   assign busy_o  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//==============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder (2 and 0 waits).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req2, we2, ready2, err2, busy2;
   logic [31:0] addr2, wdata2, rdata2;
   logic        req0, we0, ready0, err0, busy0;
   logic [31:0] addr0, wdata0, rdata0;

   int tests = 0;
   int fails = 0;

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .reset(reset), .req_i(req2), .we_i(we2), .addr_i(addr2),
      .wdata_i(wdata2), .rdata_o(rdata2), .ready_o(ready2), .err_o(err2), .busy_o(busy2)
   );

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_i(req0), .we_i(we0), .addr_i(addr0),
      .wdata_i(wdata0), .rdata_o(rdata0), .ready_o(ready0), .err_o(err0), .busy_o(busy0)
   );

   // Cycle-by-cycle handshake invariants on both instances.
   logic r2_prev = 1'b0, e2_prev = 1'b0, r0_prev = 1'b0, e0_prev = 1'b0;
   always @(negedge clk) begin
      tests++;
      if (ready2 === 1'b1 && busy2 !== 1'b1) begin
         fails++; $display("FAIL mon2_ready_busy: busy=%b while ready=1, need busy=1", busy2);
      end
      tests++;
      if (ready2 === 1'b1 && r2_prev === 1'b1) begin
         fails++; $display("FAIL mon2_ready_twice: ready=1 two cycles running, need single pulse");
      end
      tests++;
      if (err2 === 1'b1 && e2_prev !== 1'b1 && ready2 !== 1'b1) begin
         fails++; $display("FAIL mon2_err_rise: err rose with ready=%b, need ready=1", ready2);
      end
      tests++;
      if (ready0 === 1'b1 && busy0 !== 1'b1) begin
         fails++; $display("FAIL mon0_ready_busy: busy=%b while ready=1, need busy=1", busy0);
      end
      tests++;
      if (ready0 === 1'b1 && r0_prev === 1'b1) begin
         fails++; $display("FAIL mon0_ready_twice: ready=1 two cycles running, need single pulse");
      end
      tests++;
      if (err0 === 1'b1 && e0_prev !== 1'b1 && ready0 !== 1'b1) begin
         fails++; $display("FAIL mon0_err_rise: err rose with ready=%b, need ready=1", ready0);
      end
      r2_prev = ready2; e2_prev = err2; r0_prev = ready0; e0_prev = err0;
   end

   // Issue one request on the 2-wait instance; returns at the ready negedge.
   task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat);
      @(negedge clk);
      req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
      @(negedge clk);
      req2 = 1'b0;
      lat = 1;
      while (ready2 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req2 = 1'b0; we2 = 1'b0; addr2 = 32'd0; wdata2 = 32'd0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
      repeat (2) @(negedge clk);
      tests++;
      if ({ready2, err2, busy2} !== 3'b000 || rdata2 !== 32'd0) begin
         fails++;
         $display("FAIL reset2: ready/err/busy=%b rdata=%h, need 000 and 0",
                  {ready2, err2, busy2}, rdata2);
      end
      tests++;
      if ({ready0, err0, busy0} !== 3'b000 || rdata0 !== 32'd0) begin
         fails++;
         $display("FAIL reset0: ready/err/busy=%b rdata=%h, need 000 and 0",
                  {ready0, err0, busy0}, rdata0);
      end
   endtask

   task automatic test_store_load();
      int lat;
      // Release reset and request together: the first edge must accept.
      reset = 1'b0;
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h64; wdata2 = 32'd7;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1 || k == 5) req2 = 1'b0;
         tests++;
         if (ready2 !== (k == 3 || k == 7) || busy2 !== (k != 4 && k != 8)) begin
            fails++;
            $display("FAIL store_load_timing c+%0d: ready=%b busy=%b, need ready=%b busy=%b",
                     k, ready2, busy2, (k == 3 || k == 7), (k != 4 && k != 8));
         end
         if (k == 3) begin
            tests++;
            if (err2 !== 1'b0) begin
               fails++; $display("FAIL store_err: err=%b, need 0", err2);
            end
         end
         if (k == 4) begin
            req2 = 1'b1; we2 = 1'b0; addr2 = 32'h64;
         end
         if (k == 7) begin
            tests++;
            if (rdata2 !== 32'd7 || err2 !== 1'b0) begin
               fails++; $display("FAIL load_after_store: rdata=%h err=%b, need 7 and 0", rdata2, err2);
            end
         end
      end
      txn2(1'b1, 32'h64, 32'd9, lat);
      tests++;
      if (lat != 3 || rdata2 !== 32'd7 || err2 !== 1'b0) begin
         fails++;
         $display("FAIL store_old_word: lat=%0d rdata=%h err=%b, need 3, 7, 0", lat, rdata2, err2);
      end
      txn2(1'b0, 32'h64, 32'd0, lat);
      tests++;
      if (rdata2 !== 32'd9) begin
         fails++; $display("FAIL load_new_word: rdata=%h, need 9", rdata2);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (rdata2 !== 32'd9 || err2 !== 1'b0 || busy2 !== 1'b0) begin
         fails++;
         $display("FAIL rdata_hold: rdata=%h err=%b busy=%b, need 9, 0, 0", rdata2, err2, busy2);
      end
   endtask

   task automatic test_faults();
      int lat;
      txn2(1'b1, 32'h0, 32'h1111_1111, lat);
      txn2(1'b0, 32'h66, 32'h0, lat);
      tests++;
      if (lat != 3 || err2 !== 1'b1 || rdata2 !== 32'd0) begin
         fails++;
         $display("FAIL misaligned_load: lat=%0d err=%b rdata=%h, need 3, 1, 0", lat, err2, rdata2);
      end
      @(negedge clk);
      tests++;
      if (err2 !== 1'b1 || ready2 !== 1'b0) begin
         fails++; $display("FAIL err_hold: err=%b ready=%b, need 1 and 0", err2, ready2);
      end
      txn2(1'b1, 32'h100, 32'hDEAD_BEEF, lat);
      tests++;
      if (err2 !== 1'b1 || rdata2 !== 32'd0) begin
         fails++; $display("FAIL range_store: err=%b rdata=%h, need 1 and 0", err2, rdata2);
      end
      txn2(1'b0, 32'h8000_0000, 32'h0, lat);
      tests++;
      if (err2 !== 1'b1 || rdata2 !== 32'd0) begin
         fails++; $display("FAIL high_bits_load: err=%b rdata=%h, need 1 and 0", err2, rdata2);
      end
      txn2(1'b0, 32'h0, 32'h0, lat);
      tests++;
      if (err2 !== 1'b0 || rdata2 !== 32'h1111_1111) begin
         fails++; $display("FAIL word0_intact: err=%b rdata=%h, need 0 and 11111111", err2, rdata2);
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int seen;
      txn2(1'b1, 32'h10, 32'hCAFE_F00D, lat);
      @(negedge clk);
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h10; wdata2 = 32'h1234;
      @(negedge clk);
      req2 = 1'b0;
      reset = 1'b1;
      #1;
      tests++;
      if ({busy2, ready2, err2} !== 3'b000 || rdata2 !== 32'd0) begin
         fails++;
         $display("FAIL reset_abort_now: busy/ready/err=%b rdata=%h, need 000 and 0",
                  {busy2, ready2, err2}, rdata2);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (ready2 === 1'b1) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++; $display("FAIL reset_no_ready: %0d ready pulses, need 0", seen);
      end
      txn2(1'b0, 32'h10, 32'h0, lat);
      tests++;
      if (lat != 3 || rdata2 !== 32'hCAFE_F00D) begin
         fails++;
         $display("FAIL reset_no_write: lat=%0d rdata=%h, need 3 and cafef00d", lat, rdata2);
      end
   endtask

   task automatic test_in_flight();
      int lat;
      txn2(1'b1, 32'h24, 32'h5555, lat);
      @(negedge clk);
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h1111;
      @(negedge clk);
      req2 = 1'b0; addr2 = 32'h24; wdata2 = 32'hFFFF;
      lat = 1;
      while (ready2 !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      tests++;
      if (lat != 3 || err2 !== 1'b0) begin
         fails++; $display("FAIL in_flight_resp: lat=%0d err=%b, need 3 and 0", lat, err2);
      end
      txn2(1'b0, 32'h20, 32'h0, lat);
      tests++;
      if (rdata2 !== 32'h1111) begin
         fails++; $display("FAIL in_flight_0x20: rdata=%h, need 1111", rdata2);
      end
      txn2(1'b0, 32'h24, 32'h0, lat);
      tests++;
      if (rdata2 !== 32'h5555) begin
         fails++; $display("FAIL in_flight_0x24: rdata=%h, need 5555", rdata2);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'hA5A5_A5A5; vals[1] = 32'h1234_5678; vals[2] = 32'h0000_0000;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h60; wdata0 = vals[0];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (ready0 !== 1'b1 || err0 !== 1'b0) begin
            fails++; $display("FAIL b2b_store_resp[%0d]: ready=%b err=%b, need 1 and 0", i, ready0, err0);
         end
         if (i > 0) begin
            tests++;
            if (rdata0 !== vals[i-1]) begin
               fails++; $display("FAIL b2b_store_old[%0d]: rdata=%h, need %h", i, rdata0, vals[i-1]);
            end
         end
         we0 = 1'b0;
         @(negedge clk);
         tests++;
         if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
            fails++; $display("FAIL b2b_idle_a[%0d]: ready=%b busy=%b, need 0 and 0", i, ready0, busy0);
         end
         @(negedge clk);
         tests++;
         if (ready0 !== 1'b1 || rdata0 !== vals[i]) begin
            fails++; $display("FAIL b2b_load[%0d]: ready=%b rdata=%h, need 1 and %h", i, ready0, rdata0, vals[i]);
         end
         if (i < 2) begin
            we0 = 1'b1; wdata0 = vals[i+1];
         end else begin
            req0 = 1'b0;
         end
         @(negedge clk);
         tests++;
         if (ready0 !== 1'b0) begin
            fails++; $display("FAIL b2b_idle_b[%0d]: ready=%b, need 0", i, ready0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_faults();
      test_reset_abort();
      test_in_flight();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the storage array.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request acceptance and response; legal range 0-15.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  core request strobe, sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address; word index addr[31:2].
REQ-008 wdata  input  32  store data; sampled with req.
REQ-009 rdata  output  32  load data; valid while ready=1.
REQ-010 ready  output  1  single-cycle response strobe.
REQ-011 err  output  1  access fault; valid while ready=1.
REQ-012 busy  output  1  high in WAIT and RESP, low in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1 at a rising edge, the block SHALL latch addr, we and wdata. It SHALL go to WAIT with the wait counter loaded to WAIT_CYCLES, or go directly to RESP when WAIT_CYCLES=0.
REQ-015 In IDLE with req=0, the block SHALL stay in IDLE.
REQ-016 In WAIT, the counter SHALL decrement by 1 per cycle. On the edge where the counter equals 1, the block SHALL go to RESP.
REQ-017 RESP SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: req=1 in IDLE cycle c SHALL give ready=1 in cycle c+WAIT_CYCLES+1 only.
REQ-019 req, we, addr and wdata SHALL be ignored in WAIT and RESP. Changing them after acceptance SHALL NOT affect the transaction in flight.
REQ-020 A req held high continuously SHALL be accepted again in the IDLE cycle that follows RESP. Back-to-back throughput is therefore one transaction per WAIT_CYCLES+2 cycles.
REQ-021 Fault condition: the latched addr[1:0] is nonzero, or the latched addr[31:2] >= DEPTH. The block SHALL evaluate this once, at acceptance.
REQ-022 On a fault, during RESP: err=1, rdata=0, and no storage write.
REQ-023 Load without fault: rdata SHALL equal storage[latched addr[31:2]] during RESP, with err=0.
REQ-024 Store without fault: storage[latched addr[31:2]] SHALL take the latched wdata on the rising edge that ends RESP. During RESP, rdata SHALL equal the old word and err=0.
REQ-025 A load accepted immediately after a store to the same word SHALL return the new data.
REQ-026 rdata and err SHALL hold their RESP values until the next RESP.
REQ-027 ready SHALL be 1 only in RESP. busy SHALL equal (state != IDLE).
REQ-028 Address arithmetic SHALL use only addr[31:2] for indexing. Upper bits SHALL NOT be truncated: they count toward the fault check, with no aliasing.

Reset
REQ-029 On reset assertion, the block SHALL immediately set: state=IDLE, wait counter=0, ready=0, err=0, busy=0, rdata=0.
REQ-030 Reset during WAIT or RESP SHALL abort the transaction. No storage write SHALL occur and no ready pulse SHALL be produced.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 The first request SHALL be accepted on the first rising edge with reset low and req=1.

Verification
REQ-033 WAIT_CYCLES=2. Store we=1, addr=0x64, wdata=7 in cycle c -> ready=1, err=0 in cycle c+3 only; busy=1 in c+1..c+3. Then a load from 0x64 -> rdata=7, ready in c+7.
REQ-034 WAIT_CYCLES=0. req held high with alternating store 0x60<-0xA5A5A5A5 and load 0x60 -> ready every 2nd cycle; the load returns 0xA5A5A5A5.
REQ-035 Load addr=0x66 (misaligned) -> err=1, rdata=0. Store addr=0x100 (index 64 >= DEPTH) -> err=1 and storage word 0 unchanged.
REQ-036 Store 0x10<-0x1234 with reset pulsed in the first WAIT cycle -> no ready pulse, busy=0 immediately. A later load of 0x10 returns the prior contents.
REQ-037 After acceptance of a store to 0x20, change addr to 0x24 and wdata to 0xFFFF during WAIT -> 0x20 is written with the original data and 0x24 is untouched.
REQ-038 Any cycle: ready=1 implies busy=1; ready is never high in two consecutive cycles; err=1 only while ready=1 (first RESP).
